fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/if_id_latch.sv | 53 +++++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: bubble word, PC step and fetch FSM encoding.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] PC_INC        = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DROP = 2'b10,
    ST_HELD = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/if_id_latch.sv
// IF/ID pipeline register: load on enable, flush forces the bubble word, PC untouched on flush.
module if_id_latch
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);

  logic [31:0] instr_d, instr_q;
  logic [31:0] pc_d, pc_q;

  // next IF/ID contents; flush overrides any load of the instruction word
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    if (enable) begin
      instr_d = instr_in;
      pc_d    = pc_in;
    end else begin
      instr_d = instr_q;
      pc_d    = pc_q;
    end
    if (flush) begin
      instr_d = NOP_INSTR;
      pc_d    = pc_q;
    end else begin
      instr_d = instr_d;
    end
  end

  // IF/ID storage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0000_0000;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request FSM, PC/redirect tracking and a one-word holding buffer feeding IF/ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_enable,
  input  logic        if_id_enable,
  input  logic        mux_sel_IF,
  input  logic        IF_flush,
  input  logic [31:0] pc_branch_value,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        fetch_stall
);

  fetch_state_e state_d, state_q;
  logic        req_d, req_q;
  logic [31:0] addr_d, addr_q;
  logic [31:0] target_d, target_q;
  logic [31:0] buf_instr_d, buf_instr_q;
  logic [31:0] buf_pc_d, buf_pc_q;
  logic        ld_en_s;
  logic [31:0] ld_instr_s;
  logic [31:0] ld_pc_s;

  // next-state, request and IF/ID load selection
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    target_d    = target_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    ld_en_s     = 1'b0;
    ld_instr_s  = NOP_INSTR;
    ld_pc_s     = pc_out;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_BUSY;
        req_d   = 1'b1;
        addr_d  = RESET_PC;
      end
      ST_BUSY: begin
        if (imem_ack) begin
          if (mux_sel_IF) begin
            ld_en_s = 1'b1;
            addr_d  = pc_branch_value;
          end else if (pc_enable && if_id_enable) begin
            ld_en_s    = 1'b1;
            ld_instr_s = imem_rdata;
            ld_pc_s    = addr_q;
            addr_d     = addr_q + PC_INC;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = addr_q;
            req_d       = 1'b0;
            state_d     = ST_HELD;
          end
        end else if (mux_sel_IF) begin
          target_d = pc_branch_value;
          state_d  = ST_DROP;
        end else if (if_id_enable) begin
          ld_en_s = 1'b1;
        end else begin
          ld_en_s = 1'b0;
        end
      end
      ST_DROP: begin
        ld_en_s = if_id_enable;
        // a redirect arriving with the ack is newer than the saved target
        if (imem_ack) begin
          state_d = ST_BUSY;
          addr_d  = mux_sel_IF ? pc_branch_value : target_q;
        end else if (mux_sel_IF) begin
          target_d = pc_branch_value;
        end else begin
          target_d = target_q;
        end
      end
      ST_HELD: begin
        if (mux_sel_IF) begin
          ld_en_s = 1'b1;
          req_d   = 1'b1;
          addr_d  = pc_branch_value;
          state_d = ST_BUSY;
        end else if (pc_enable && if_id_enable) begin
          ld_en_s    = 1'b1;
          ld_instr_s = buf_instr_q;
          ld_pc_s    = buf_pc_q;
          req_d      = 1'b1;
          addr_d     = buf_pc_q + PC_INC;
          state_d    = ST_BUSY;
        end else begin
          ld_en_s = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        addr_d  = RESET_PC;
      end
    endcase
  end

  // fetch state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      addr_q      <= RESET_PC;
      target_q    <= 32'h0000_0000;
      buf_instr_q <= 32'h0000_0000;
      buf_pc_q    <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      target_q    <= target_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  if_id_latch #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clock     (clock),
    .reset     (reset),
    .enable    (ld_en_s),
    .flush     (IF_flush),
    .instr_in  (ld_instr_s),
    .pc_in     (ld_pc_s),
    .instr_out (instruction_out),
    .pc_out    (pc_out)
  );

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign fetch_stall = ((state_q == ST_BUSY) || (state_q == ST_DROP)) && !imem_ack;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; memory returns addr ^ 32'h5A5A_0000.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        pc_enable = 1'b1;
  logic        if_id_enable = 1'b1;
  logic        mux_sel_IF = 1'b0;
  logic        IF_flush = 1'b0;
  logic [31:0] pc_branch_value = 32'h0000_0000;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        fetch_stall;

  logic        auto_ack = 1'b1;
  logic        ack_m = 1'b0;
  int          errors = 0;
  int          checks = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  assign imem_ack   = auto_ack ? imem_req : ack_m;
  assign imem_rdata = imem_addr ^ KEY;

  always #5 clock = ~clock;

  fetch_unit dut (
    .clock(clock), .reset(reset), .pc_enable(pc_enable), .if_id_enable(if_id_enable),
    .mux_sel_IF(mux_sel_IF), .IF_flush(IF_flush), .pc_branch_value(pc_branch_value),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction_out(instruction_out), .pc_out(pc_out), .fetch_stall(fetch_stall)
  );

  task automatic restart();
    @(negedge clock);
    reset = 1'b0; auto_ack = 1'b1; ack_m = 1'b0;
    pc_enable = 1'b1; if_id_enable = 1'b1; mux_sel_IF = 1'b0; IF_flush = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    checks++; if (instruction_out !== NOP) begin errors++; $display("FAIL rst_instr got %h exp %h", instruction_out, NOP); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc_out); end
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", fetch_stall); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] ea, ep;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      ea = 32'(i) * 32'd4;
      checks++; if (imem_addr !== ea || imem_req !== 1'b1)
        begin errors++; $display("FAIL zw_addr%0d got %h/%b exp %h/1", i, imem_addr, imem_req, ea); end
      if (i > 0) begin
        ep = ea - 32'd4;
        checks++; if (pc_out !== ep || instruction_out !== (ep ^ KEY))
          begin errors++; $display("FAIL zw_ifid%0d got %h:%h exp %h:%h", i, pc_out, instruction_out, ep, ep ^ KEY); end
      end
    end
  endtask

  task automatic test_wait_state();
    restart();
    repeat (3) @(negedge clock);
    checks++; if (imem_addr !== 32'd8) begin errors++; $display("FAIL ws_start got %h exp 8", imem_addr); end
    auto_ack = 1'b0; ack_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      checks++; if (fetch_stall !== 1'b1 || instruction_out !== NOP || imem_addr !== 32'd8)
        begin errors++; $display("FAIL ws_stall%0d got %b/%h/%h exp 1/%h/8", i, fetch_stall, instruction_out, imem_addr, NOP); end
    end
    ack_m = 1'b1;
    @(negedge clock); #1;
    checks++; if (instruction_out !== (32'd8 ^ KEY) || pc_out !== 32'd8 || imem_addr !== 32'd12)
      begin errors++; $display("FAIL ws_word got %h/%h/%h exp %h/8/c", instruction_out, pc_out, imem_addr, 32'd8 ^ KEY); end
    ack_m = 1'b0; auto_ack = 1'b1;
  endtask

  task automatic test_held();
    @(negedge clock); #1;
    checks++; if (imem_addr !== 32'd16 || instruction_out !== (32'd12 ^ KEY))
      begin errors++; $display("FAIL hd_pre got %h/%h exp 10/%h", imem_addr, instruction_out, 32'd12 ^ KEY); end
    pc_enable = 1'b0; if_id_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      checks++; if (imem_req !== 1'b0 || instruction_out !== (32'd12 ^ KEY) || pc_out !== 32'd12)
        begin errors++; $display("FAIL hd_hold%0d got %b/%h/%h exp 0/%h/c", i, imem_req, instruction_out, pc_out, 32'd12 ^ KEY); end
    end
    pc_enable = 1'b1; if_id_enable = 1'b1;
    @(negedge clock); #1;
    checks++; if (instruction_out !== (32'd16 ^ KEY) || pc_out !== 32'd16 || imem_req !== 1'b1 || imem_addr !== 32'd20)
      begin errors++; $display("FAIL hd_rel got %h/%h/%b/%h exp %h/10/1/14", instruction_out, pc_out, imem_req, imem_addr, 32'd16 ^ KEY); end
    @(negedge clock); #1;
    checks++; if (pc_out !== 32'd20 || imem_addr !== 32'd24)
      begin errors++; $display("FAIL hd_next got %h/%h exp 14/18", pc_out, imem_addr); end
  endtask

  task automatic test_redirect_drop();
    auto_ack = 1'b0; ack_m = 1'b0; mux_sel_IF = 1'b1; pc_branch_value = 32'h0000_0040;
    @(negedge clock);
    mux_sel_IF = 1'b0; pc_branch_value = 32'h0000_0000;
    #1;
    checks++; if (imem_addr !== 32'd24 || imem_req !== 1'b1 || fetch_stall !== 1'b1)
      begin errors++; $display("FAIL dr_pend got %h/%b/%b exp 18/1/1", imem_addr, imem_req, fetch_stall); end
    ack_m = 1'b1;
    @(negedge clock); #1;
    checks++; if (imem_addr !== 32'h40 || instruction_out !== NOP)
      begin errors++; $display("FAIL dr_drop got %h/%h exp 40/%h", imem_addr, instruction_out, NOP); end
    ack_m = 1'b0; auto_ack = 1'b1;
    @(negedge clock); #1;
    checks++; if (instruction_out !== (32'h40 ^ KEY) || pc_out !== 32'h40 || imem_addr !== 32'h44)
      begin errors++; $display("FAIL dr_tgt got %h/%h/%h exp %h/40/44", instruction_out, pc_out, imem_addr, 32'h40 ^ KEY); end
  endtask

  task automatic test_flush();
    IF_flush = 1'b1;
    @(negedge clock); #1;
    IF_flush = 1'b0;
    checks++; if (instruction_out !== NOP || pc_out !== 32'h40 || imem_addr !== 32'h48)
      begin errors++; $display("FAIL fl_ack got %h/%h/%h exp %h/40/48", instruction_out, pc_out, imem_addr, NOP); end
  endtask

  task automatic test_wrap();
    mux_sel_IF = 1'b1; pc_branch_value = 32'hFFFF_FFFC;
    @(negedge clock); #1;
    mux_sel_IF = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC || instruction_out !== NOP)
      begin errors++; $display("FAIL wr_redir got %h/%h exp fffffffc/%h", imem_addr, instruction_out, NOP); end
    @(negedge clock); #1;
    checks++; if (imem_addr !== 32'h0 || pc_out !== 32'hFFFF_FFFC || instruction_out !== (32'hFFFF_FFFC ^ KEY))
      begin errors++; $display("FAIL wr_wrap got %h/%h/%h exp 0/fffffffc/%h", imem_addr, pc_out, instruction_out, 32'hFFFF_FFFC ^ KEY); end
  endtask

  task automatic test_reset_mid();
    auto_ack = 1'b0; ack_m = 1'b0;
    @(negedge clock); #1;
    checks++; if (imem_req !== 1'b1 || fetch_stall !== 1'b1)
      begin errors++; $display("FAIL rm_busy got %b/%b exp 1/1", imem_req, fetch_stall); end
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instruction_out !== NOP || pc_out !== 32'h0 || fetch_stall !== 1'b0)
      begin errors++; $display("FAIL rm_async got %b/%h/%h/%h/%b exp 0/0/%h/0/0", imem_req, imem_addr, instruction_out, pc_out, fetch_stall, NOP); end
    ack_m = 1'b1;
    @(negedge clock); #1;
    checks++; if (imem_req !== 1'b0 || instruction_out !== NOP)
      begin errors++; $display("FAIL rm_ackign got %b/%h exp 0/%h", imem_req, instruction_out, NOP); end
    ack_m = 1'b0; reset = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0)
      begin errors++; $display("FAIL rm_idle got %b exp 0", imem_req); end
    @(negedge clock); #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin errors++; $display("FAIL rm_first got %b/%h exp 1/0", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_state();
    test_held();
    test_redirect_drop();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
